bram_burst_reader: RTL and testbench

Read-side burst engine for the 64-bit accelerator block RAMs (SP, DP and HASH buffers). Given a base address and word count, it drives one BRAM port's address, fetches consecutive words through the synchronous (1-cycle) read path, and presents them on a valid/ready stream with a last-beat flag. It sits between a BRAM port and a consumer such as the matrix datapath or the hash absorber. The internal credit-counted FIFO absorbs read latency and consumer backpressure without losing words.

---
 rtl/bram_burst_reader.sv | 214 +++++++++++++++++++++
 tb/tb_bram_burst_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_burst_reader.sv
// -----------------------------------------------------------------------------
// bram_burst_reader
//
// Read-side burst engine for the 64-bit accelerator block RAMs. A start pulse
// with a base byte address and word count makes the engine issue consecutive
// reads on one BRAM port. The words returned by the 1-cycle synchronous read
// path are presented on a valid/ready stream, with m_last on the final word.
// A small credit-counted FIFO absorbs read latency and consumer backpressure.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             1-cycle request, only sampled while idle
//   base_addr, len    burst byte address / word count, sampled on start
//   busy, done        burst in progress / 1-cycle completion pulse
//   bram_addr         BRAM port address (holds when no read is issued)
//   bram_ren          read issued this cycle, data on bram_rdata next cycle
//   bram_wen          tied low, this engine never writes
//   bram_rdata        BRAM read data
//   m_valid/m_data/m_last/m_ready   output stream
// -----------------------------------------------------------------------------
module bram_burst_reader #(
    parameter int unsigned ADDR_STEP  = 8,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [31:0]      bram_addr,
    output logic             bram_ren,
    output logic             bram_wen,
    input  logic [63:0]      bram_rdata,
    output logic             m_valid,
    output logic [63:0]      m_data,
    output logic             m_last,
    input  logic             m_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] beat_q, beat_d;      // index of the word at the stream head
    logic             inflight_q, inflight_d;
    logic             done_q, done_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      mem_q [FIFO_DEPTH];

    logic             head_valid;
    logic             pop;
    logic             push;
    logic             pop_fifo;
    logic [CNT_W:0]   occ;
    logic             issue;
    logic             last_issue;
    logic             last_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Stream head and credit logic.
    // The word landing on bram_rdata is exposed straight onto the stream when
    // the FIFO is empty, so the first beat is visible the cycle after its
    // read. If that word is accepted immediately it never enters storage.
    // ------------------------------------------------------------------------
    always_comb begin
        head_valid = (count_q != '0);
        m_valid    = head_valid | inflight_q;
        m_data     = head_valid ? mem_q[rd_ptr_q] : (inflight_q ? bram_rdata : '0);
        m_last     = m_valid && (beat_q == len_q - LEN_W'(1));
        pop        = m_valid & m_ready;
        pop_fifo   = pop & head_valid;
        push       = inflight_q & ~(pop & ~head_valid);
        // Words fetched but not yet consumed after this cycle's pop; a new
        // read is allowed only while that stays below the buffer depth, so a
        // pop in this cycle frees a credit for an issue in this same cycle.
        occ        = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}
                   - {{CNT_W{1'b0}}, pop};
        issue      = (state_q == S_RUN) && (issued_q != len_q) && (occ < DEPTH_C);
        last_issue = issue && ((issued_q + LEN_W'(1)) == len_q);
        last_pop   = pop && m_last;
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && (len != '0)) state_d = S_RUN;
            S_RUN:   if (last_issue)           state_d = S_DRAIN;
            // The final beat can only be accepted once its read has landed,
            // so its handshake also means the buffer is now empty.
            S_DRAIN: if (last_pop)             state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != S_IDLE);
        bram_ren  = issue;
        bram_wen  = 1'b0;
        bram_addr = addr_q;
        done      = done_q;
    end

    // ------------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------------
    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        beat_d     = beat_q;
        inflight_d = issue;
        done_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop_fifo);

        if ((state_q == S_IDLE) && start) begin
            if (len != '0) begin
                addr_d   = base_addr;
                len_d    = len;
                issued_d = '0;
                beat_d   = '0;
            end else begin
                // Empty burst: acknowledge without touching the BRAM port.
                done_d = 1'b1;
            end
        end

        if (issue) begin
            addr_d   = addr_q + 32'(ADDR_STEP);   // wraps modulo 2^32
            issued_d = issued_q + LEN_W'(1);
        end

        if (pop)                                beat_d   = beat_q + LEN_W'(1);
        if ((state_q == S_DRAIN) && last_pop)   done_d   = 1'b1;
        if (push)                               wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_fifo)                           rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bram_rdata;
        end
    end

    // The credit rule must keep storage from overflowing.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> (({1'b0, count_q} < DEPTH_C) || pop));

endmodule

// File: tb/tb_bram_burst_reader.sv
module tb_bram_burst_reader;

    localparam int DEPTH = 2;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        start      = 1'b0;
    logic [31:0] base_addr  = '0;
    logic [15:0] len        = '0;
    logic        busy;
    logic        done;
    logic [31:0] bram_addr;
    logic        bram_ren;
    logic        bram_wen;
    logic [63:0] bram_rdata = '0;
    logic        m_valid;
    logic [63:0] m_data;
    logic        m_last;
    logic        m_ready    = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bram_burst_reader #(.ADDR_STEP(8), .LEN_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .bram_addr(bram_addr), .bram_ren(bram_ren),
        .bram_wen(bram_wen), .bram_rdata(bram_rdata), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    // BRAM contents: low byte at 0x100 + 8*i is 0xA0 + i.
    function automatic logic [63:0] bram_word(input logic [31:0] a);
        return {a, (a >> 3) + 32'h80};
    endfunction

    always @(posedge clk) if (bram_ren) bram_rdata <= bram_word(bram_addr);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: a burst is a list of words to fetch; 'vis' holds the
    // words fetched and not yet consumed (at most DEPTH of them).
    // ------------------------------------------------------------------------
    bit          md_busy   = 0;
    bit          md_done   = 0;
    logic [15:0] md_len    = '0;
    logic [15:0] md_issued = '0;
    logic [15:0] md_beats  = '0;
    logic [31:0] md_addr   = '0;
    logic [63:0] vis[$];

    int          beat_cnt  = 0;
    int          done_cnt  = 0;
    logic [31:0] ren_addrs[$];

    always @(negedge clk) begin : model_p
        bit          ev, el, pp, er, was_busy;
        logic [63:0] ed;
        if (rst) begin
            md_busy = 0; md_done = 0; md_len = '0; md_issued = '0;
            md_beats = '0; md_addr = '0; vis.delete();
            chk("rst_busy",  busy,      0);
            chk("rst_done",  done,      0);
            chk("rst_ren",   bram_ren,  0);
            chk("rst_addr",  bram_addr, 0);
            chk("rst_valid", m_valid,   0);
            chk("rst_data",  m_data,    0);
            chk("rst_last",  m_last,    0);
        end else begin
            ev = (vis.size() != 0);
            ed = ev ? vis[0] : 64'h0;
            el = ev && (md_beats == md_len - 16'd1);
            pp = ev && m_ready;
            er = md_busy && (md_issued < md_len) && ((vis.size() - int'(pp)) < DEPTH);

            chk("busy",  busy,      md_busy);
            chk("done",  done,      md_done);
            chk("ren",   bram_ren,  er);
            chk("wen",   bram_wen,  0);
            chk("addr",  bram_addr, md_addr);
            chk("valid", m_valid,   ev);
            chk("last",  m_last,    el);
            if (ev) chk("data", m_data, ed);

            if (m_valid && m_ready) beat_cnt++;
            if (done) done_cnt++;
            if (bram_ren) ren_addrs.push_back(bram_addr);

            was_busy = md_busy;
            md_done  = 0;
            if (pp) begin
                void'(vis.pop_front());
                md_beats++;
                if (md_beats == md_len) begin md_busy = 0; md_done = 1; end
            end
            if (er) begin
                vis.push_back(bram_word(md_addr));
                md_addr   = md_addr + 32'd8;
                md_issued = md_issued + 16'd1;
            end
            if (!was_busy && start) begin
                if (len == 16'd0) md_done = 1;
                else begin
                    md_busy = 1; md_len = len; md_addr = base_addr;
                    md_issued = '0; md_beats = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        beat_cnt = 0; done_cnt = 0; ren_addrs.delete();
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] l);
        start = 1'b1; base_addr = b; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (rnd) begin
                m_ready = 1'($urandom_range(0, 1));
                if (md_busy && $urandom_range(0, 7) == 0) begin
                    start = 1'b1; base_addr = $urandom; len = 16'($urandom_range(0, 20));
                end else start = 1'b0;
            end
            @(negedge clk);
            if (done) seen = 1;
            tick();
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
    endtask

    logic        r_ren[8];
    logic [31:0] r_addr[8];
    logic        r_v[8], r_l[8], r_d[8];
    logic [63:0] r_data[8];

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // T1: straight burst, consumer always ready
        m_ready = 1'b1; clear_obs();
        do_start(32'h100, 16'd4);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            r_ren[c] = bram_ren; r_addr[c] = bram_addr; r_v[c] = m_valid;
            r_l[c] = m_last; r_d[c] = done; r_data[c] = m_data;
            tick();
        end
        chk("t1_ren1",   r_ren[1], 1);
        chk("t1_addr1",  r_addr[1], 32'h100);
        chk("t1_addr4",  r_addr[4], 32'h118);
        chk("t1_ren5",   r_ren[5], 0);
        chk("t1_v1",     r_v[1], 0);
        chk("t1_data2",  r_data[2][31:0], 32'hA0);
        chk("t1_data5",  r_data[5][31:0], 32'hA3);
        chk("t1_last4",  r_l[4], 0);
        chk("t1_last5",  r_l[5], 1);
        chk("t1_done5",  r_d[5], 0);
        chk("t1_done6",  r_d[6], 1);
        chk("t1_beats",  beat_cnt, 4);

        // T2: consumer stalled for cycles 0..9
        m_ready = 1'b0; clear_obs();
        do_start(32'h100, 16'd4);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 9) begin
                chk("t2_reads_stalled", ren_addrs.size(), 2);
                chk("t2_hold_data", m_data[31:0], 32'hA0);
                chk("t2_hold_valid", m_valid, 1);
            end
            tick();
        end
        m_ready = 1'b1;
        wait_done(40, 0);
        chk("t2_beats", beat_cnt, 4);
        chk("t2_reads", ren_addrs.size(), 4);

        // T3: zero-length burst
        clear_obs();
        do_start(32'h40, 16'd0);
        @(negedge clk);
        chk("t3_done1", done, 1);
        tick(); tick(); tick();
        chk("t3_beats", beat_cnt, 0);
        chk("t3_reads", ren_addrs.size(), 0);
        chk("t3_dones", done_cnt, 1);

        // T4: address wrap
        clear_obs();
        do_start(32'hFFFF_FFF8, 16'd3);
        wait_done(30, 0);
        chk("t4_reads", ren_addrs.size(), 3);
        if (ren_addrs.size() == 3) begin
            chk("t4_a0", ren_addrs[0], 32'hFFFF_FFF8);
            chk("t4_a1", ren_addrs[1], 32'h0);
            chk("t4_a2", ren_addrs[2], 32'h8);
        end
        chk("t4_beats", beat_cnt, 3);

        // T5: start while busy is ignored
        clear_obs();
        do_start(32'h300, 16'd4);
        tick();
        start = 1'b1; base_addr = 32'h500; len = 16'd7;
        tick();
        start = 1'b0;
        wait_done(30, 0);
        repeat (5) tick();
        chk("t5_beats", beat_cnt, 4);
        chk("t5_dones", done_cnt, 1);

        // T6: reset mid-burst, then a fresh burst
        clear_obs();
        do_start(32'h400, 16'd8);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_valid", m_valid, 0);
        chk("t6_addr", bram_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        clear_obs();
        do_start(32'h200, 16'd2);
        wait_done(30, 0);
        chk("t6_beats", beat_cnt, 2);
        chk("t6_dones", done_cnt, 1);
        if (ren_addrs.size() == 2) begin
            chk("t6_a0", ren_addrs[0], 32'h200);
            chk("t6_a1", ren_addrs[1], 32'h208);
        end else chk("t6_reads", ren_addrs.size(), 2);

        // Random bursts with random backpressure and stray starts
        for (int k = 0; k < 30; k++) begin
            logic [15:0] l;
            l = 16'($urandom_range(0, 12));
            clear_obs();
            m_ready = 1'($urandom_range(0, 1));
            do_start($urandom, l);
            wait_done(8 * int'(l) + 40, 1);
            chk("rnd_beats", beat_cnt, l);
            chk("rnd_dones", done_cnt, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
